// File: rtl/sysmem_pkg.sv
// Shared encodings and sizes for the system-memory arbiter.
package sysmem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
  typedef enum logic {OWN_CPU = 1'b0, OWN_LD = 1'b1} owner_t;
  localparam int SYSMEM_WORDS = 1024;
  localparam int LANES        = 4;
endpackage

// File: rtl/sysmem_rr_pick.sv
// Two-way round-robin chooser: a lone requester wins, a tie goes to the one not served last.
module sysmem_rr_pick
  import sysmem_pkg::*;
(
  input  logic   i_cpu_valid,
  input  logic   i_ld_valid,
  input  owner_t i_last_grant,
  output logic   o_grant,
  output owner_t o_owner
);
  assign o_grant = i_cpu_valid | i_ld_valid;

  always_comb begin
    o_owner = OWN_CPU;
    if (i_cpu_valid && i_ld_valid)
      o_owner = (i_last_grant == OWN_CPU) ? OWN_LD : OWN_CPU;
    else if (i_ld_valid)
      o_owner = OWN_LD;
  end
endmodule

// File: rtl/sysmem_arbiter.sv
// CPU/loader arbiter for the four byte-lane system BRAMs; fixed IDLE->ACCESS->RESP sequence.
// Define SYSMEM_ARB_WP_EN to drop CPU writes to the first WP_WORDS words.
module sysmem_arbiter
  import sysmem_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned WP_WORDS  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_valid,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_wstrb,
  output logic              cpu_ready,
  output logic [31:0]       cpu_rdata,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_wdata,
  input  logic [3:0]        ld_wstrb,
  output logic              ld_ready,
  output logic [31:0]       ld_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LANES-1:0]  mem_ce,
  output logic [LANES-1:0]  mem_we,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout,
  output logic              oor_err
);
`ifdef SYSMEM_ARB_WP_EN
  localparam bit WP_ON = 1'b1;
`else
  localparam bit WP_ON = 1'b0;
`endif

  state_t            r_state, w_state_nxt;
  owner_t            r_owner, r_last;
  logic              r_oor;
  logic              w_grant;
  owner_t            w_owner;
  logic              w_cpu_in_range, w_wp, w_blk;
  logic [ADDR_W-1:0] w_cpu_idx;
  logic [3:0]        w_strb;

  sysmem_rr_pick u_pick (
    .i_cpu_valid (cpu_valid),
    .i_ld_valid  (ld_valid),
    .i_last_grant(r_last),
    .o_grant     (w_grant),
    .o_owner     (w_owner)
  );

  assign w_cpu_in_range = cpu_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2];
  assign w_cpu_idx      = cpu_addr[ADDR_W+1:2];
  assign w_wp   = WP_ON && w_cpu_in_range && (cpu_wstrb != 4'h0) &&
                  (32'(w_cpu_idx) < WP_WORDS);
  // Blocked CPU accesses still run the full sequence, just with every lane idle.
  assign w_blk  = (w_owner == OWN_CPU) && (!w_cpu_in_range || w_wp);
  assign w_strb = (w_owner == OWN_CPU) ? cpu_wstrb : ld_wstrb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    cpu_ready   = 1'b0;
    ld_ready    = 1'b0;
    cpu_rdata   = '0;
    ld_rdata    = '0;
    case (r_state)
      IDLE:    if (w_grant) w_state_nxt = ACCESS;
      ACCESS:  w_state_nxt = RESP;
      RESP: begin
        w_state_nxt = IDLE;
        if (r_owner == OWN_CPU) begin
          cpu_ready = 1'b1;
          cpu_rdata = r_oor ? '0 : mem_dout;
        end else begin
          ld_ready = 1'b1;
          ld_rdata = mem_dout;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner  <= OWN_CPU;
      r_last   <= OWN_LD;
      r_oor    <= 1'b0;
      mem_addr <= '0;
      mem_ce   <= '0;
      mem_we   <= '0;
      mem_din  <= '0;
      oor_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_grant) begin
          r_owner  <= w_owner;
          r_last   <= w_owner;
          r_oor    <= (w_owner == OWN_CPU) && !w_cpu_in_range;
          mem_addr <= (w_owner == OWN_CPU) ? w_cpu_idx : ld_addr;
          mem_din  <= (w_owner == OWN_CPU) ? cpu_wdata : ld_wdata;
          if ((w_owner == OWN_CPU) && !w_cpu_in_range) oor_err <= 1'b1;
          if (w_blk) begin
            mem_ce <= '0;
            mem_we <= '0;
          end else begin
            mem_ce <= (w_strb == 4'h0) ? 4'hF : w_strb;
            mem_we <= w_strb;
          end
        end
        ACCESS: begin
          mem_ce <= '0;
          mem_we <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule
